banked_frame_buffer: RTL and testbench

Parametrised, double-buffered, banked pixel frame buffer for the GPU. The draw side writes single pixels into the back buffer by (x,y). The scan-out side reads pixels from the front buffer by (x,y) with fixed latency. The block adds a hardware clear engine (fills the back buffer NUM_BANKS pixels per cycle) and a vblank-synchronised front/back swap handshake.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_bank.sv | 31 +++
 rtl/banked_frame_buffer.sv | 178 +++++++++++++++++
 tb/tb_banked_frame_buffer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and sizing helpers for the banked frame buffer.
// Provides the FSM state type, bank/depth/address sizing and pixel linearisation.
package fb_pkg;

    typedef enum logic {
        FB_IDLE  = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_t;

    function automatic int fb_num_banks(input int bank_bits);
        return 1 << bank_bits;
    endfunction

    function automatic int fb_depth(input int h_res, input int v_res,
                                    input int bank_bits);
        return (h_res * v_res) >> bank_bits;
    endfunction

    function automatic int fb_addr_w(input int h_res, input int v_res);
        return $clog2(h_res * v_res);
    endfunction

    function automatic logic [31:0] fb_lin_addr(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input int h_res);
        return y * 32'(h_res) + x;
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM holding both buffers' words.
// Ports: clk, i_we/i_waddr/i_wdata write port, i_re/i_raddr read port, o_rdata registered.
module fb_bank #(
    parameter int WORDS = 9600,
    parameter int PIX_W = 8,
    parameter int AW    = 14
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [WORDS];
    logic [PIX_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_frame_buffer.sv
// Double-buffered banked frame buffer with clear engine and vblank-synced swap.
// Ports: clk/reset, draw write (wr_*), scan-out read (rd_*), clear (clear_*), swap (swap_*, vblank, front_sel).
module banked_frame_buffer
    import fb_pkg::*;
#(
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int PIX_W     = 8,
    parameter int BANK_BITS = 4,
    parameter int COORD_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [PIX_W-1:0]   wr_pixel,
    input  logic               rd_en,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_valid,
    output logic [PIX_W-1:0]   rd_pixel,
    input  logic               clear_start,
    input  logic [PIX_W-1:0]   clear_color,
    output logic               clear_busy,
    input  logic               swap_req,
    input  logic               vblank,
    output logic               swap_done,
    output logic               front_sel
);

    localparam int NUM_BANKS = fb_num_banks(BANK_BITS);
    localparam int DEPTH     = fb_depth(H_RES, V_RES, BANK_BITS);
    localparam int ADDR_W    = fb_addr_w(H_RES, V_RES);
    localparam int WORD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH - 1);

    fb_state_t          r_state;
    logic [WORD_W-1:0]  r_clr_cnt;
    logic [PIX_W-1:0]   r_clr_color;
    logic               r_pending;
    logic               r_wr_ready;
    logic               r_clear_busy;
    logic               r_swap_done;
    logic               r_front_sel;

    logic               r_rd_v1;
    logic [BANK_BITS-1:0] r_rd_bank1;
    logic               r_rd_inr1;
    logic               r_rd_valid;
    logic [PIX_W-1:0]   r_rd_pixel;

    logic [ADDR_W-1:0]    w_wr_lin;
    logic [ADDR_W-1:0]    w_rd_lin;
    logic                 w_wr_inr;
    logic                 w_rd_inr;
    logic [BANK_BITS-1:0] w_wr_bank;
    logic [BANK_BITS-1:0] w_rd_bank;
    logic [WORD_W-1:0]    w_wr_word;
    logic [WORD_W-1:0]    w_rd_word;
    logic                 w_wr_fire;
    logic                 w_swap_go;
    logic [WORD_W:0]      w_wr_addr;
    logic [WORD_W:0]      w_rd_addr;
    logic [PIX_W-1:0]     w_wr_data;
    logic [NUM_BANKS-1:0] w_we;
    logic [PIX_W-1:0]     w_rd_q [NUM_BANKS];

    assign w_wr_lin  = ADDR_W'(fb_lin_addr(32'(wr_x), 32'(wr_y), H_RES));
    assign w_rd_lin  = ADDR_W'(fb_lin_addr(32'(rd_x), 32'(rd_y), H_RES));
    assign w_wr_inr  = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign w_rd_inr  = (rd_x < X_LIM) && (rd_y < Y_LIM);
    assign w_wr_bank = w_wr_lin[BANK_BITS-1:0];
    assign w_rd_bank = w_rd_lin[BANK_BITS-1:0];
    assign w_wr_word = WORD_W'(w_wr_lin >> BANK_BITS);
    assign w_rd_word = WORD_W'(w_rd_lin >> BANK_BITS);

    // Out-of-range writes still handshake but never reach a bank.
    assign w_wr_fire = wr_valid && r_wr_ready && w_wr_inr;

    // Back buffer is ~front_sel for both draw and clear; clear owns the port while busy.
    assign w_wr_addr = {~r_front_sel, r_clear_busy ? r_clr_cnt : w_wr_word};
    assign w_wr_data = r_clear_busy ? r_clr_color : wr_pixel;
    assign w_rd_addr = {r_front_sel, w_rd_word};

    assign w_swap_go = r_pending && vblank && (r_state == FB_IDLE) && !clear_start;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_we[b] = r_clear_busy ||
                             (w_wr_fire && (w_wr_bank == BANK_BITS'(b)));
            fb_bank #(
                .WORDS (2 * DEPTH),
                .PIX_W (PIX_W),
                .AW    (WORD_W + 1)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_we[b]),
                .i_waddr (w_wr_addr),
                .i_wdata (w_wr_data),
                .i_re    (rd_en),
                .i_raddr (w_rd_addr),
                .o_rdata (w_rd_q[b])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FB_IDLE;
            r_clr_cnt    <= '0;
            r_clr_color  <= '0;
            r_pending    <= 1'b0;
            r_wr_ready   <= 1'b1;
            r_clear_busy <= 1'b0;
            r_swap_done  <= 1'b0;
            r_front_sel  <= 1'b0;
        end else begin
            r_swap_done <= w_swap_go;
            if (w_swap_go) begin
                r_front_sel <= ~r_front_sel;
                r_pending   <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                FB_IDLE: begin
                    if (clear_start) begin
                        r_state      <= FB_CLEAR;
                        r_clr_cnt    <= '0;
                        r_clr_color  <= clear_color;
                        r_clear_busy <= 1'b1;
                        r_wr_ready   <= 1'b0;
                    end
                end
                FB_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_WORD) begin
                        r_state      <= FB_IDLE;
                        r_clear_busy <= 1'b0;
                        r_wr_ready   <= 1'b1;
                    end
                end
                default: r_state <= FB_IDLE;
            endcase
        end
    end

    // Stage 1 tracks the bank RAM read; stage 2 registers the bank mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_v1    <= 1'b0;
            r_rd_bank1 <= '0;
            r_rd_inr1  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_pixel <= '0;
        end else begin
            r_rd_v1    <= rd_en;
            r_rd_bank1 <= w_rd_bank;
            r_rd_inr1  <= w_rd_inr;
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_rd_pixel <= r_rd_inr1 ? w_rd_q[r_rd_bank1] : '0;
            end
        end
    end

    assign wr_ready   = r_wr_ready;
    assign clear_busy = r_clear_busy;
    assign swap_done  = r_swap_done;
    assign front_sel  = r_front_sel;
    assign rd_valid   = r_rd_valid;
    assign rd_pixel   = r_rd_pixel;

endmodule

// File: tb/tb_banked_frame_buffer.sv
// Self-checking bench for banked_frame_buffer: scoreboarded reads plus
// per-cycle control checks against a pixel-array reference model.
module tb_banked_frame_buffer;

    localparam int H     = 320;
    localparam int V     = 240;
    localparam int NPIX  = H * V;
    localparam int DEPTH = NPIX / 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_x = '0;
    logic [15:0] wr_y = '0;
    logic [7:0]  wr_pixel = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_x = '0;
    logic [15:0] rd_y = '0;
    logic        rd_valid;
    logic [7:0]  rd_pixel;
    logic        clear_start = 1'b0;
    logic [7:0]  clear_color = '0;
    logic        clear_busy;
    logic        swap_req = 1'b0;
    logic        vblank = 1'b0;
    logic        swap_done;
    logic        front_sel;

    always #5 clk = ~clk;

    banked_frame_buffer dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_valid(rd_valid), .rd_pixel(rd_pixel),
        .clear_start(clear_start), .clear_color(clear_color),
        .clear_busy(clear_busy),
        .swap_req(swap_req), .vblank(vblank),
        .swap_done(swap_done), .front_sel(front_sel)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    // Reference model: two full pixel images plus a known-contents map.
    logic [7:0] mm [2][NPIX];
    bit         kn [2][NPIX];
    int         m_front = 0;
    bit         m_pend = 1'b0;
    int         m_busy = 0;
    bit         e_swap_done = 1'b0;

    typedef struct {
        logic [7:0] px;
        bit         chk;
        int         due;
    } rexp_t;
    rexp_t sbq[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit in_range(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    task automatic model_edge();
        bit idle;
        bit go;
        int back;
        int x, y, l;
        rexp_t e;
        if (reset) begin
            if (m_busy > 0) begin
                for (int i = 0; i < NPIX; i++) kn[1 - m_front][i] = 1'b0;
            end
            m_front = 0;
            m_pend = 1'b0;
            m_busy = 0;
            e_swap_done = 1'b0;
            return;
        end
        idle = (m_busy == 0);
        back = 1 - m_front;
        go = m_pend && vblank && idle && !clear_start;
        if (wr_valid && idle) begin
            x = int'(wr_x);
            y = int'(wr_y);
            if (in_range(x, y)) begin
                l = y * H + x;
                mm[back][l] = wr_pixel;
                kn[back][l] = 1'b1;
            end
        end
        if (rd_en) begin
            x = int'(rd_x);
            y = int'(rd_y);
            e.due = cyc + 1;
            if (in_range(x, y)) begin
                l = y * H + x;
                e.px = mm[m_front][l];
                e.chk = kn[m_front][l];
            end else begin
                e.px = 8'h00;
                e.chk = 1'b1;
            end
            sbq.push_back(e);
        end
        if (!idle) begin
            m_busy--;
        end else if (clear_start) begin
            for (int i = 0; i < NPIX; i++) begin
                mm[back][i] = clear_color;
                kn[back][i] = 1'b1;
            end
            m_busy = DEPTH;
        end
        e_swap_done = go;
        if (go) begin
            m_front = 1 - m_front;
            m_pend = 1'b0;
        end else if (swap_req) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        rexp_t e;
        if (mon_on) begin
            check("wr_ready", 32'(wr_ready), 32'(m_busy == 0));
            check("clear_busy", 32'(clear_busy), 32'(m_busy > 0));
            check("front_sel", 32'(front_sel), 32'(m_front));
            check("swap_done", 32'(swap_done), 32'(e_swap_done));
            if (rd_valid) begin
                if (sbq.size() == 0) begin
                    check("rd_spurious", 32'(rd_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rd_latency", 32'(cyc), 32'(e.due));
                    if (e.chk) check("rd_pixel", 32'(rd_pixel), 32'(e.px));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("rd_missing", 32'(rd_valid), 32'd1);
            end
        end
    end

    task automatic do_write(input int x, input int y, input logic [7:0] px);
        wr_valid = 1'b1;
        wr_x = 16'(x);
        wr_y = 16'(y);
        wr_pixel = px;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input int x, input int y);
        rd_en = 1'b1;
        rd_x = 16'(x);
        rd_y = 16'(y);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_swap();
        vblank = 1'b1;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        int f0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NPIX; i++) kn[b][i] = 1'b0;

        // Reset
        reset = 1'b1;
        tick();
        mon_on = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_front", 32'(front_sel), 32'd0);
        check("rst_rd_pixel", 32'(rd_pixel), 32'd0);

        // Write (5,2) to the back buffer, swap, read back
        do_write(5, 2, 8'hA7);
        do_swap();
        check("swap1_front", 32'(front_sel), 32'd1);
        do_read(5, 2);
        run(3);

        // Clear engine: 0x3C over the back buffer, writes blocked
        clear_color = 8'h3C;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        clear_color = 8'h00;
        n = int'(clear_busy);
        for (int k = 0; k < 4810; k++) begin
            wr_valid = (k < 4700) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_x = 16'($urandom_range(0, 400));
            wr_y = 16'($urandom_range(0, 260));
            wr_pixel = 8'($urandom);
            clear_start = (k < 4000) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (clear_busy) n++;
        end
        wr_valid = 1'b0;
        clear_start = 1'b0;
        check("clear_cycles", 32'(n), 32'(DEPTH));
        do_swap();
        do_read(0, 0);
        do_read(319, 239);
        do_read(160, 120);
        run(3);

        // Swap waits for vblank; a second request merges
        vblank = 1'b0;
        f0 = m_front;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            swap_req = (k == 50);
            tick();
            if (swap_done) n++;
        end
        swap_req = 1'b0;
        check("no_swap_wo_vblank", 32'(n), 32'd0);
        vblank = 1'b1;
        tick();
        check("swap_first_vblank", 32'(swap_done), 32'd1);
        n = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (swap_done) n++;
        end
        check("swap_once", 32'(n), 32'd1);
        check("swap_toggle", 32'(front_sel), 32'(1 - f0));

        // Out-of-range writes dropped, out-of-range read returns 0
        do_write(0, 1, 8'h11);
        do_write(320, 0, 8'hFF);
        do_write(0, 240, 8'hFF);
        do_swap();
        do_read(0, 1);
        do_read(400, 10);
        run(3);

        // Row 0 known in both buffers, then streaming reads with a swap mid-stream
        for (int p = 0; p < 2; p++) begin
            for (int x = 0; x < 32; x++) do_write(x, 0, 8'($urandom));
            do_swap();
        end
        vblank = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            rd_x = 16'(i);
            rd_y = 16'd0;
            wr_valid = 1'b1;
            wr_x = 16'($urandom_range(0, 31));
            wr_y = 16'd0;
            wr_pixel = 8'($urandom);
            swap_req = (i == 16);
            tick();
        end
        rd_en = 1'b0;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        run(4);

        // Fill the back buffer so random reads hit known contents everywhere
        clear_color = 8'h5A;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        run(DEPTH + 2);

        // Random mixed traffic
        for (int k = 0; k < 400; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_x = 16'($urandom_range(0, 340));
            wr_y = 16'(($urandom_range(0, 7) == 0) ? $urandom_range(236, 250)
                                                    : $urandom_range(0, 3));
            wr_pixel = 8'($urandom);
            rd_en = 1'($urandom_range(0, 1));
            rd_x = 16'($urandom_range(0, 340));
            rd_y = 16'(($urandom_range(0, 7) == 0) ? $urandom_range(236, 250)
                                                    : $urandom_range(0, 3));
            swap_req = ($urandom_range(0, 15) == 0);
            vblank = 1'($urandom_range(0, 1));
            tick();
        end
        wr_valid = 1'b0;
        rd_en = 1'b0;
        swap_req = 1'b0;
        run(4);

        // Reset in the middle of a clear with a swap pending
        vblank = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        clear_color = 8'h77;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        run(998);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(clear_busy), 32'd0);
        check("mid_rst_front", 32'(front_sel), 32'd0);
        check("mid_rst_swap_done", 32'(swap_done), 32'd0);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        do_write(3, 3, 8'h42);
        do_swap();
        do_read(3, 3);
        run(5);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
